stove_controller: RTL and testbench
===================================

// Module: stove_controller
// PURPOSE
//  Control panel for a 4-burner electric stove (FPGA board top-level logic).
//  Debounced-level buttons turn the stove on/off, toggle a child lock, and
//  raise/lower the power level (0-9) of the burner selected by two switches.
//  Two active-low 7-segment outputs show the selected burner and its level.
// PARAMETERS
//  REPEAT_DELAY  16  cycles a held inc_pwr/dec_pwr must stay high per extra auto-repeat step (>=2)
// PORTS
//  clk         in   1  single system clock, all logic on rising edge
//  reset       in   1  synchronous, active-high reset
//  sw_h        in   1  burner select MSB (switch, level)
//  sw_l        in   1  burner select LSB; burner = {sw_h,sw_l}+1 (1..4)
//  child_lock  in   1  button, active high; rising edge toggles lock
//  inc_pwr     in   1  button, active high; raise selected burner level
//  dec_pwr     in   1  button, active high; lower selected burner level
//  pwr         in   1  button, active high; rising edge toggles stove on/off
//  left_hex    out  8  7-seg {dp,g,f,e,d,c,b,a}, active low, registered
//  right_hex   out  8  7-seg {dp,g,f,e,d,c,b,a}, active low, registered
// BEHAVIOUR
//  - Reset: state OFF, lock=0, all four levels=0, repeat counters=0, button
//    history regs=0, left_hex=right_hex=8'hFF (blank). Reset wins over all inputs.
//  - Edge detect: each button has a prev register; press = in & ~prev. A button
//    already high when reset releases counts as a press on first cycle.
//  - Press sampled at edge k updates state at edge k; hex outputs at edge k+1.
//  - FSM states: OFF, ON.
//    OFF: pwr press -> ON only if lock=0; inc/dec ignored.
//    ON : pwr press -> OFF regardless of lock (safety); all levels cleared to 0.
//  - child_lock press toggles lock in either state; lock persists across on/off.
//  - ON & lock=0: inc press -> level[sel]+1, saturate at 9; dec press ->
//    level[sel]-1, saturate at 0. inc and dec both pressed/held same cycle: no change.
//  - Auto-repeat: while inc (or dec) stays high after its press, counter counts
//    cycles; every REPEAT_DELAY cycles one further step applies; counter clears on
//    release or when the other button is high. Locked or OFF: no steps, counter 0.
//  - pwr and inc pressed same cycle in OFF: turn ON only, no level change.
//  - Switch changes take effect immediately (display next cycle); levels of
//    non-selected burners retained.
//  - Display: OFF&!lock: FF/FF. OFF&lock: left='L'(C7), right FF.
//    ON&!lock: left=burner digit 1..4, right=level digit. ON&lock: left='L', right=level.
//  - Digit codes: 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90; dp always 1.
// TESTING
//  1 reset held 3 cycles -> both hex FF; release, no input -> still FF, state OFF.
//  2 pwr pulse 1 cycle, sw=00 -> left F9 ('1'), right C0 ('0') two edges later.
//  3 ON, sw=10, three 1-cycle inc pulses -> left B0 ('3'), right B0 (3); sw=00 -> right C0.
//  4 ON, inc held 12 cycles with REPEAT_DELAY=4 -> levels 1 +2 steps = 3... saturate at 9 when held long.
//  5 child_lock+inc held 20 cycles, then pwr pulse in OFF -> stays OFF, left C7; second
//    lock press, pwr pulse -> ON; lock while ON then pwr -> OFF, levels cleared.
//  6 ON, level 5, assert reset mid-hold of inc -> next edge state OFF, outputs FF next cycle.

Source files
------------

// File: rtl/stove_controller.sv
// Four-burner stove control panel: power/lock/level buttons with edge detect and
// auto-repeat, driving two registered active-low 7-segment displays.
module stove_controller #(
   parameter int unsigned REPEAT_DELAY = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sw_h,
   input  logic       sw_l,
   input  logic       child_lock,
   input  logic       inc_pwr,
   input  logic       dec_pwr,
   input  logic       pwr,
   output logic [7:0] left_hex,
   output logic [7:0] right_hex
);

   localparam int unsigned CW = $clog2(REPEAT_DELAY);
   localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [7:0] SEG_L     = 8'hC7;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic {S_OFF = 1'b0, S_ON = 1'b1} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_lock;
   logic          r_lock_prev, r_inc_prev, r_dec_prev, r_pwr_prev;
   logic [3:0]    r_level [4];
   logic [CW-1:0] r_inc_cnt, r_dec_cnt;
   logic [CW-1:0] w_inc_cnt_nxt, w_dec_cnt_nxt;
   logic          w_lock_press, w_inc_press, w_dec_press, w_pwr_press;
   logic          w_active, w_inc_step, w_dec_step;
   logic [1:0]    w_sel;
   logic [3:0]    w_cur_level;
   logic [7:0]    w_left_nxt, w_right_nxt;

   function automatic logic [7:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 8'hC0;
         4'd1:    f_seg = 8'hF9;
         4'd2:    f_seg = 8'hA4;
         4'd3:    f_seg = 8'hB0;
         4'd4:    f_seg = 8'h99;
         4'd5:    f_seg = 8'h92;
         4'd6:    f_seg = 8'h82;
         4'd7:    f_seg = 8'hF8;
         4'd8:    f_seg = 8'h80;
         4'd9:    f_seg = 8'h90;
         default: f_seg = SEG_BLANK;
      endcase
   endfunction

   assign w_lock_press = child_lock & ~r_lock_prev;
   assign w_inc_press  = inc_pwr    & ~r_inc_prev;
   assign w_dec_press  = dec_pwr    & ~r_dec_prev;
   assign w_pwr_press  = pwr        & ~r_pwr_prev;
   assign w_sel        = {sw_h, sw_l};
   assign w_cur_level  = r_level[w_sel];
   assign w_active     = (r_state == S_ON) & ~r_lock;

   // A step fires on the press itself, then every REPEAT_DELAY held cycles.
   always_comb begin
      w_inc_step    = 1'b0;
      w_dec_step    = 1'b0;
      w_inc_cnt_nxt = '0;
      w_dec_cnt_nxt = '0;
      if (w_active && inc_pwr && !dec_pwr) begin
         if (w_inc_press || r_inc_cnt == CNT_LAST)
            w_inc_step = 1'b1;
         else
            w_inc_cnt_nxt = r_inc_cnt + CW'(1);
      end
      if (w_active && dec_pwr && !inc_pwr) begin
         if (w_dec_press || r_dec_cnt == CNT_LAST)
            w_dec_step = 1'b1;
         else
            w_dec_cnt_nxt = r_dec_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_OFF;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_OFF:   if (w_pwr_press && !r_lock) w_state_nxt = S_ON;
         S_ON:    if (w_pwr_press)            w_state_nxt = S_OFF;
         default: w_state_nxt = S_OFF;
      endcase
   end

   always_comb begin
      w_left_nxt  = SEG_BLANK;
      w_right_nxt = SEG_BLANK;
      case (r_state)
         S_OFF: begin
            if (r_lock) w_left_nxt = SEG_L;
         end
         S_ON: begin
            w_left_nxt  = r_lock ? SEG_L : f_seg({2'b00, w_sel} + 4'd1);
            w_right_nxt = f_seg(w_cur_level);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock      <= 1'b0;
         r_lock_prev <= 1'b0;
         r_inc_prev  <= 1'b0;
         r_dec_prev  <= 1'b0;
         r_pwr_prev  <= 1'b0;
         r_inc_cnt   <= '0;
         r_dec_cnt   <= '0;
         r_level     <= '{default: 4'd0};
         left_hex    <= SEG_BLANK;
         right_hex   <= SEG_BLANK;
      end else begin
         r_lock_prev <= child_lock;
         r_inc_prev  <= inc_pwr;
         r_dec_prev  <= dec_pwr;
         r_pwr_prev  <= pwr;
         r_inc_cnt   <= w_inc_cnt_nxt;
         r_dec_cnt   <= w_dec_cnt_nxt;
         left_hex    <= w_left_nxt;
         right_hex   <= w_right_nxt;
         if (w_lock_press)
            r_lock <= ~r_lock;
         // Powering off from ON always wipes every burner, even when locked.
         if (r_state == S_ON && w_pwr_press)
            r_level <= '{default: 4'd0};
         else if (w_inc_step && w_cur_level != 4'd9)
            r_level[w_sel] <= w_cur_level + 4'd1;
         else if (w_dec_step && w_cur_level != 4'd0)
            r_level[w_sel] <= w_cur_level - 4'd1;
      end
   end

endmodule

// File: tb/tb_stove_controller.sv
// Bench for stove_controller: directed scenarios plus a random run checked
// against a cycle-level behavioural model of the control panel.
module tb_stove_controller;

   localparam int RD = 4;

   logic       clk;
   logic       reset;
   logic       sw_h, sw_l;
   logic       child_lock, inc_pwr, dec_pwr, pwr;
   logic [7:0] left_hex, right_hex;

   int n_vec = 0;
   int n_err = 0;

   stove_controller #(.REPEAT_DELAY(RD)) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_h       (sw_h),
      .sw_l       (sw_l),
      .child_lock (child_lock),
      .inc_pwr    (inc_pwr),
      .dec_pwr    (dec_pwr),
      .pwr        (pwr),
      .left_hex   (left_hex),
      .right_hex  (right_hex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   // Model state: power, lock, per-burner levels, hold run lengths, button history.
   bit         m_on, m_lock;
   int         m_lvl [4];
   int         m_ninc, m_ndec;
   bit         m_pl, m_pi, m_pd, m_pp;
   logic [7:0] m_left = 8'hFF;
   logic [7:0] m_right = 8'hFF;

   function automatic void model_step(input bit rst, input bit [1:0] sw, input bit lk,
                                      input bit ic, input bit dc, input bit pw);
      bit act, s_inc, s_dec;
      int sel;
      sel = int'(sw);
      if (rst) begin
         m_on = 0; m_lock = 0; m_lvl = '{0, 0, 0, 0};
         m_ninc = 0; m_ndec = 0;
         m_pl = 0; m_pi = 0; m_pd = 0; m_pp = 0;
         m_left = 8'hFF; m_right = 8'hFF;
         return;
      end
      if (!m_on) begin
         m_left  = m_lock ? 8'hC7 : 8'hFF;
         m_right = 8'hFF;
      end else begin
         m_left  = m_lock ? 8'hC7 : SEG[sel + 1];
         m_right = SEG[m_lvl[sel]];
      end
      act = m_on && !m_lock;
      s_inc = 0; s_dec = 0;
      if (act && ic && !dc) begin
         if (!m_pi) begin m_ninc = 0; s_inc = 1; end
         else begin m_ninc++; s_inc = (m_ninc % RD == 0); end
      end else m_ninc = 0;
      if (act && dc && !ic) begin
         if (!m_pd) begin m_ndec = 0; s_dec = 1; end
         else begin m_ndec++; s_dec = (m_ndec % RD == 0); end
      end else m_ndec = 0;
      if (m_on && pw && !m_pp) begin
         m_on = 0;
         m_lvl = '{0, 0, 0, 0};
      end else begin
         if (!m_on && pw && !m_pp && !m_lock) m_on = 1;
         if (s_inc && m_lvl[sel] < 9) m_lvl[sel]++;
         if (s_dec && m_lvl[sel] > 0) m_lvl[sel]--;
      end
      if (lk && !m_pl) m_lock = !m_lock;
      m_pl = lk; m_pi = ic; m_pd = dc; m_pp = pw;
   endfunction

   task automatic tick(input bit rst, input bit [1:0] sw, input bit lk,
                       input bit ic, input bit dc, input bit pw);
      @(negedge clk);
      reset = rst; {sw_h, sw_l} = sw;
      child_lock = lk; inc_pwr = ic; dec_pwr = dc; pwr = pw;
      @(posedge clk);
      model_step(rst, sw, lk, ic, dc, pw);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1, 2'b00, 0, 0, 0, 0);
         n_vec++;
         if ({left_hex, right_hex} !== 16'hFFFF) begin
            n_err++; $display("FAIL reset_hold got %h want FFFF", {left_hex, right_hex});
         end
      end
      for (int i = 0; i < 2; i++) begin
         tick(0, 2'b00, 0, 0, 0, 0);
         n_vec++;
         if ({left_hex, right_hex} !== 16'hFFFF) begin
            n_err++; $display("FAIL reset_idle got %h want FFFF", {left_hex, right_hex});
         end
      end
   endtask

   task automatic test_power_on();
      tick(0, 2'b00, 0, 0, 0, 1);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hFFFF) begin
         n_err++; $display("FAIL pwr_latency got %h want FFFF", {left_hex, right_hex});
      end
      tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hF9C0) begin
         n_err++; $display("FAIL pwr_on got %h want F9C0", {left_hex, right_hex});
      end
   endtask

   task automatic test_levels();
      for (int i = 0; i < 3; i++) begin
         tick(0, 2'b10, 0, 1, 0, 0);
         tick(0, 2'b10, 0, 0, 0, 0);
      end
      n_vec++;
      if ({left_hex, right_hex} !== 16'hB0B0) begin
         n_err++; $display("FAIL inc_pulses got %h want B0B0", {left_hex, right_hex});
      end
      tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hF9C0) begin
         n_err++; $display("FAIL switch_sel got %h want F9C0", {left_hex, right_hex});
      end
   endtask

   task automatic test_autorepeat();
      for (int i = 0; i < 12; i++) tick(0, 2'b01, 0, 1, 0, 0);
      tick(0, 2'b01, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hA4B0) begin
         n_err++; $display("FAIL repeat_12 got %h want A4B0", {left_hex, right_hex});
      end
      for (int i = 0; i < 40; i++) tick(0, 2'b01, 0, 1, 0, 0);
      tick(0, 2'b01, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hA490) begin
         n_err++; $display("FAIL repeat_sat9 got %h want A490", {left_hex, right_hex});
      end
      for (int i = 0; i < 40; i++) tick(0, 2'b01, 0, 0, 1, 0);
      tick(0, 2'b01, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hA4C0) begin
         n_err++; $display("FAIL repeat_sat0 got %h want A4C0", {left_hex, right_hex});
      end
      tick(0, 2'b11, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'h99C0) begin
         n_err++; $display("FAIL burner4 got %h want 99C0", {left_hex, right_hex});
      end
   endtask

   task automatic test_child_lock();
      tick(0, 2'b00, 0, 0, 0, 1); tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hFFFF) begin
         n_err++; $display("FAIL pwr_off got %h want FFFF", {left_hex, right_hex});
      end
      for (int i = 0; i < 20; i++) tick(0, 2'b00, 1, 1, 0, 0);
      tick(0, 2'b00, 0, 0, 0, 1); tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hC7FF) begin
         n_err++; $display("FAIL locked_off got %h want C7FF", {left_hex, right_hex});
      end
      tick(0, 2'b00, 1, 0, 0, 0); tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hFFFF) begin
         n_err++; $display("FAIL unlock_off got %h want FFFF", {left_hex, right_hex});
      end
      tick(0, 2'b00, 0, 0, 0, 1); tick(0, 2'b00, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick(0, 2'b00, 0, 1, 0, 0); tick(0, 2'b00, 0, 0, 0, 0);
      end
      tick(0, 2'b00, 1, 0, 0, 0); tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hC7A4) begin
         n_err++; $display("FAIL lock_on got %h want C7A4", {left_hex, right_hex});
      end
      tick(0, 2'b00, 0, 1, 0, 0); tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hC7A4) begin
         n_err++; $display("FAIL locked_inc got %h want C7A4", {left_hex, right_hex});
      end
      tick(0, 2'b00, 0, 0, 0, 1); tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hC7FF) begin
         n_err++; $display("FAIL locked_pwr_off got %h want C7FF", {left_hex, right_hex});
      end
      tick(0, 2'b00, 1, 0, 0, 0); tick(0, 2'b00, 0, 0, 0, 0);
      tick(0, 2'b00, 0, 0, 0, 1); tick(0, 2'b00, 0, 0, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hF9C0) begin
         n_err++; $display("FAIL levels_cleared got %h want F9C0", {left_hex, right_hex});
      end
   endtask

   task automatic test_reset_mid_hold();
      for (int i = 0; i < 4; i++) begin
         tick(0, 2'b00, 0, 1, 0, 0); tick(0, 2'b00, 0, 0, 0, 0);
      end
      for (int i = 0; i < 3; i++) tick(0, 2'b00, 0, 1, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hF992) begin
         n_err++; $display("FAIL level5 got %h want F992", {left_hex, right_hex});
      end
      tick(1, 2'b00, 0, 1, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hFFFF) begin
         n_err++; $display("FAIL reset_mid_hold got %h want FFFF", {left_hex, right_hex});
      end
      for (int i = 0; i < 6; i++) tick(0, 2'b00, 0, 1, 0, 0);
      n_vec++;
      if ({left_hex, right_hex} !== 16'hFFFF) begin
         n_err++; $display("FAIL after_reset_hold got %h want FFFF", {left_hex, right_hex});
      end
      tick(0, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      bit [1:0] sw;
      bit lk, ic, dc, pw, rst;
      sw = 0; lk = 0; ic = 0; dc = 0; pw = 0;
      tick(1, sw, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) sw = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) lk = !lk;
         if ($urandom_range(0, 24) == 0) pw = !pw;
         if ($urandom_range(0, 5) == 0)  ic = !ic;
         if ($urandom_range(0, 7) == 0)  dc = !dc;
         tick(rst, sw, lk, ic, dc, pw);
         n_vec++;
         if ({left_hex, right_hex} !== {m_left, m_right}) begin
            n_err++;
            $display("FAIL random cycle %0d got %h want %h", i, {left_hex, right_hex}, {m_left, m_right});
         end
      end
   endtask

   initial begin
      reset = 1'b1; sw_h = 1'b0; sw_l = 1'b0;
      child_lock = 1'b0; inc_pwr = 1'b0; dec_pwr = 1'b0; pwr = 1'b0;
      test_reset();
      test_power_on();
      test_levels();
      test_autorepeat();
      test_child_lock();
      test_reset_mid_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
